// File: rtl/mux_n_1_rr_reg.sv
// N-input, W-bit registered multiplexor with valid/ready handshake per channel.
// Fixed-select or round-robin grant feeds a one-entry output register.
module mux_n_1_rr_reg #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel_fixed,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] rr_ptr;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load;
    logic             xfer;

    // Grant selection: fixed index, or first valid channel at/after rr_ptr.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(sel_fixed) == i && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Walk farthest-to-nearest so the channel closest to rr_ptr wins.
            for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= int'(NUM_CH)) begin
                    idx = idx - int'(NUM_CH);
                end
                if (in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(idx);
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(grant_idx) == i) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage next-state and handshake.
    always_comb begin
        state_d  = state_q;
        load     = (state_q == S_EMPTY) || out_ready;
        xfer     = reset_L && load && grant_valid;
        in_ready = '0;
        if (load) begin
            state_d = grant_valid ? S_FULL : S_EMPTY;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (xfer && 32'(grant_idx) == i) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source channel and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            out_data <= grant_data;
            out_ch   <= grant_idx;
            if (mode) begin
                rr_ptr <= (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    assign out_valid = (state_q == S_FULL);

endmodule

// File: tb/tb_mux_n_1_rr_reg.sv
// Self-checking bench for mux_n_1_rr_reg: 4-channel instance with a reference
// model and scoreboard, plus a 3-channel instance for the out-of-range select.
module tb_mux_n_1_rr_reg;

    logic       clk;
    logic       reset_L;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic       mode;
    logic [1:0] sel_fixed;
    logic [1:0] out_data;
    logic       out_valid;
    logic [1:0] out_ch;
    logic       out_ready;

    logic [5:0] in_data3;
    logic [2:0] in_valid3;
    logic [2:0] in_ready3;
    logic       mode3;
    logic [1:0] sel3;
    logic [1:0] out_data3;
    logic       out_valid3;
    logic [1:0] out_ch3;
    logic       out_ready3;

    mux_n_1_rr_reg #(.WIDTH(2), .NUM_CH(4), .SEL_W(2)) u_dut (
        .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel_fixed(sel_fixed), .out_data(out_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_n_1_rr_reg #(.WIDTH(2), .NUM_CH(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset_L(reset_L), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel_fixed(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    typedef struct packed {
        logic [1:0] data;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vecs = 0;
    int   errs = 0;

    // Reference model state
    int         m_ptr = 0;
    bit         m_valid = 0;
    bit         last_xfer;
    logic [3:0] exp_rdy;
    logic [3:0] obs_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_grant(output int g, output bit gv);
        int c;
        gv = 0;
        g  = 0;
        if (!mode) begin
            if (in_valid[sel_fixed]) begin
                gv = 1;
                g  = int'(sel_fixed);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!gv && in_valid[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
    endtask

    // Advance one clock: predict the handshake, push the expected word, update model.
    task automatic tick();
        int g;
        bit gv;
        bit ld;
        #1;
        model_grant(g, gv);
        ld        = !m_valid || out_ready;
        last_xfer = reset_L && ld && gv;
        exp_rdy   = '0;
        if (last_xfer) exp_rdy[g] = 1'b1;
        obs_rdy = in_ready;
        if (last_xfer) sb.push_back({in_data[g*2 +: 2], 2'(g)});
        @(posedge clk);
        #1;
        if (!reset_L) begin
            m_valid = 0;
            m_ptr   = 0;
        end else if (last_xfer) begin
            m_valid = 1;
            if (mode) m_ptr = (g == 3) ? 0 : g + 1;
        end else if (ld) begin
            m_valid = 0;
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L   = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {2'b11, 2'b10, 2'b01, 2'b00};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (obs_rdy !== 4'b0000) begin errs++; $display("FAIL reset_in_ready got=%b want=0000", obs_rdy); end
            vecs++;
            if ({out_valid, out_data, out_ch} !== 5'b0) begin
                errs++; $display("FAIL reset_outputs got v=%b d=%b ch=%0d want all zero", out_valid, out_data, out_ch);
            end
            vecs++;
            if ({out_valid3, out_data3, out_ch3} !== 5'b0) begin
                errs++; $display("FAIL reset_outputs3 got v=%b d=%b ch=%0d want all zero", out_valid3, out_data3, out_ch3);
            end
        end
        reset_L = 1'b1;
        tick();
        vecs++;
        if (obs_rdy !== 4'b0001 || obs_rdy !== exp_rdy) begin errs++; $display("FAIL first_rr_ready got=%b want=0001", obs_rdy); end
        e = sb.pop_front();
        vecs++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== e.data) begin
            errs++; $display("FAIL first_rr_out got v=%b ch=%0d d=%b want v=1 ch=0 d=%b", out_valid, out_ch, out_data, e.data);
        end
    endtask

    task automatic test_fixed();
        mode      = 1'b0;
        sel_fixed = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (obs_rdy !== 4'b0100 || obs_rdy !== exp_rdy) begin errs++; $display("FAIL fixed_ready[%0d] got=%b want=0100", i, obs_rdy); end
            e = sb.pop_front();
            vecs++;
            if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'b10 || out_data !== e.data) begin
                errs++; $display("FAIL fixed_out[%0d] got v=%b ch=%0d d=%b want v=1 ch=2 d=10", i, out_valid, out_ch, out_data);
            end
        end
    endtask

    task automatic test_rr_rotation();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {2'b00, 2'b11, 2'b01, 2'b10};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++;
            if (obs_rdy !== (4'b0001 << seq[i]) || obs_rdy !== exp_rdy) begin
                errs++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, obs_rdy, 4'b0001 << seq[i]);
            end
            e = sb.pop_front();
            vecs++;
            if (out_valid !== 1'b1 || out_ch !== 2'(seq[i]) || out_data !== e.data) begin
                errs++; $display("FAIL rr_out[%0d] got ch=%0d d=%b want ch=%0d d=%b", i, out_ch, out_data, seq[i], e.data);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int seq[3] = '{1, 3, 1};
        do_reset();
        mode      = 1'b1;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            tick();
            e = sb.pop_front();
            vecs++;
            if (out_ch !== 2'(seq[i]) || out_data !== e.data || obs_rdy !== exp_rdy) begin
                errs++; $display("FAIL rr_sparse[%0d] got ch=%0d d=%b rdy=%b want ch=%0d d=%b rdy=%b",
                                 i, out_ch, out_data, obs_rdy, seq[i], e.data, exp_rdy);
            end
        end
    endtask

    task automatic test_backpressure();
        mode      = 1'b0;
        sel_fixed = 2'd1;
        in_valid  = 4'b1111;
        in_data   = {2'b11, 2'b10, 2'b01, 2'b00};
        out_ready = 1'b1;
        tick();
        e = sb.pop_front();
        vecs++;
        if (out_data !== 2'b01 || out_ch !== 2'd1 || out_data !== e.data) begin
            errs++; $display("FAIL bp_fill got ch=%0d d=%b want ch=1 d=01", out_ch, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'($urandom);
            in_valid = 4'($urandom);
            mode     = i[0];
            tick();
            vecs++;
            if (obs_rdy !== 4'b0000 || out_valid !== 1'b1 || out_data !== 2'b01 || out_ch !== 2'd1) begin
                errs++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%b ch=%0d want rdy=0000 v=1 d=01 ch=1",
                                 i, obs_rdy, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        mode      = 1'b0;
        sel_fixed = 2'd3;
        in_valid  = 4'b1000;
        in_data   = {2'b10, 2'b01, 2'b01, 2'b01};
        tick();
        vecs++;
        if (obs_rdy !== 4'b1000 || obs_rdy !== exp_rdy) begin errs++; $display("FAIL bp_release_ready got=%b want=1000", obs_rdy); end
        e = sb.pop_front();
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 2'b10 || out_ch !== 2'd3 || out_data !== e.data) begin
            errs++; $display("FAIL bp_release_out got v=%b d=%b ch=%0d want v=1 d=10 ch=3", out_valid, out_data, out_ch);
        end
        in_valid = 4'b0000;
        tick();
        vecs++;
        if (out_valid !== 1'b0 || out_data !== 2'b10 || out_ch !== 2'd3) begin
            errs++; $display("FAIL drain_hold got v=%b d=%b ch=%0d want v=0 d=10 ch=3", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_invalid_select();
        in_valid   = 4'b0000;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b111;
        in_data3   = {2'b01, 2'b10, 2'b11};
        out_ready3 = 1'b1;
        #1;
        vecs++;
        if (in_ready3 !== 3'b001) begin errs++; $display("FAIL inv_fill_ready got=%b want=001", in_ready3); end
        tick();
        vecs++;
        if (out_valid3 !== 1'b1 || out_data3 !== 2'b11 || out_ch3 !== 2'd0) begin
            errs++; $display("FAIL inv_fill_out got v=%b d=%b ch=%0d want v=1 d=11 ch=0", out_valid3, out_data3, out_ch3);
        end
        sel3 = 2'd3;
        #1;
        vecs++;
        if (in_ready3 !== 3'b000) begin errs++; $display("FAIL inv_sel_ready got=%b want=000", in_ready3); end
        tick();
        vecs++;
        if (out_valid3 !== 1'b0 || out_data3 !== 2'b11 || out_ch3 !== 2'd0) begin
            errs++; $display("FAIL inv_sel_drain got v=%b d=%b ch=%0d want v=0 d=11 ch=0", out_valid3, out_data3, out_ch3);
        end
    endtask

    initial begin
        reset_L    = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        mode       = 1'b0;
        sel_fixed  = '0;
        out_ready  = 1'b0;
        in_data3   = '0;
        in_valid3  = '0;
        mode3      = 1'b0;
        sel3       = '0;
        out_ready3 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_rr_sparse();
        test_backpressure();
        test_invalid_select();
        vecs++;
        if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
